// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage of the rv32i core plus the EX/MEM pipeline register.
// Operands are picked through forwarding muxes and fed to the combinational alu.
// The result is registered into MEM with stall, flush, valid tracking and a
// synchronous active-low reset.
// Optional feature: define EX_MEM_PERF_CNT_EN to add the saturating stall/flush
// cycle counters and their stall_cnt / flush_cnt ports.

package ex_mem_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;
endpackage

// Combinational ALU; all arithmetic wraps modulo 2^DPW.
module alu
    import ex_mem_pkg::*;
#(
    parameter int DPW = 32
) (
    input  alu_op_t        op,
    input  logic [DPW-1:0] a,
    input  logic [DPW-1:0] b,
    output logic [DPW-1:0] y
);
    localparam int SHW = $clog2(DPW);

    logic [SHW-1:0] shamt_s;

    assign shamt_s = b[SHW-1:0];

    // Operation decode; unknown opcodes produce zero.
    always_comb begin
        y = {DPW{1'b0}};
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << shamt_s;
            ALU_SRL:  y = a >> shamt_s;
            ALU_SRA:  y = $unsigned($signed(a) >>> shamt_s);
            ALU_SLT:  y = {{(DPW-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(DPW-1){1'b0}}, (a < b)};
            default:  y = {DPW{1'b0}};
        endcase
    end
endmodule

module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DPW   = 32,
    parameter int RAW   = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             validE,
    input  logic             regwriteE,
    input  logic             resultsrcE,
    input  logic             memwriteE,
    input  alu_op_t          alu_ctrlE,
    input  logic             alusrcE,
    input  logic [DPW-1:0]   Rd1E,
    input  logic [DPW-1:0]   Rd2E,
    input  logic [RAW-1:0]   RdE,
    input  logic [DPW-1:0]   immextE,
    input  logic [1:0]       forwardAE,
    input  logic [1:0]       forwardBE,
    input  logic [DPW-1:0]   resultW,
    output logic             validM,
    output logic             regwriteM,
    output logic             resultsrcM,
    output logic             memwriteM,
    output logic [DPW-1:0]   aluresultM,
    output logic [DPW-1:0]   writedataM,
    output logic [RAW-1:0]   RdM,
`ifdef EX_MEM_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic [DPW-1:0]   srcBE
);
    logic [DPW-1:0] src_a_s;
    logic [DPW-1:0] fwd_b_s;
    logic [DPW-1:0] aluresult_s;
    logic           load_s;

    // Operand A forward mux; the reserved code 11 falls back to the register file.
    always_comb begin
        src_a_s = Rd1E;
        case (forwardAE)
            2'b00:   src_a_s = Rd1E;
            2'b01:   src_a_s = resultW;
            2'b10:   src_a_s = aluresultM;
            2'b11:   src_a_s = Rd1E;
            default: src_a_s = Rd1E;
        endcase
    end

    // Operand B forward mux; the forwarded value is also the store data.
    always_comb begin
        fwd_b_s = Rd2E;
        case (forwardBE)
            2'b00:   fwd_b_s = Rd2E;
            2'b01:   fwd_b_s = resultW;
            2'b10:   fwd_b_s = aluresultM;
            2'b11:   fwd_b_s = Rd2E;
            default: fwd_b_s = Rd2E;
        endcase
    end

    // Operand B select between forwarded register data and the immediate.
    always_comb begin
        if (alusrcE) begin
            srcBE = immextE;
        end else begin
            srcBE = fwd_b_s;
        end
    end

    alu #(.DPW(DPW)) u_alu (
        .op (alu_ctrlE),
        .a  (src_a_s),
        .b  (srcBE),
        .y  (aluresult_s)
    );

    assign load_s = ~stall_i & ~flush_i;

    // EX/MEM register: reset > flush > stall > load. Write enables are gated by
    // validity, and writes to x0 never raise regwriteM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            validM     <= 1'b0;
            regwriteM  <= 1'b0;
            resultsrcM <= 1'b0;
            memwriteM  <= 1'b0;
            aluresultM <= {DPW{1'b0}};
            writedataM <= {DPW{1'b0}};
            RdM        <= {RAW{1'b0}};
        end else if (flush_i) begin
            validM     <= 1'b0;
            regwriteM  <= 1'b0;
            resultsrcM <= 1'b0;
            memwriteM  <= 1'b0;
            aluresultM <= {DPW{1'b0}};
            writedataM <= {DPW{1'b0}};
            RdM        <= {RAW{1'b0}};
        end else if (load_s) begin
            validM     <= validE;
            regwriteM  <= regwriteE & validE & (RdE != {RAW{1'b0}});
            resultsrcM <= resultsrcE;
            memwriteM  <= memwriteE & validE;
            aluresultM <= aluresult_s;
            writedataM <= fwd_b_s;
            RdM        <= RdE;
        end else begin
            validM     <= validM;
            regwriteM  <= regwriteM;
            resultsrcM <= resultsrcM;
            memwriteM  <= memwriteM;
            aluresultM <= aluresultM;
            writedataM <= writedataM;
            RdM        <= RdM;
        end
    end

`ifdef EX_MEM_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating counters of stalled (non-flushed) cycles and flushed cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= {CNT_W{1'b0}};
            flush_cnt <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            stall_cnt <= stall_cnt;
            if (flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end else begin
                flush_cnt <= flush_cnt;
            end
        end else if (stall_i) begin
            flush_cnt <= flush_cnt;
            if (stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end else begin
                stall_cnt <= stall_cnt;
            end
        end else begin
            stall_cnt <= stall_cnt;
            flush_cnt <= flush_cnt;
        end
    end
`endif

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised execute stage plus EX/MEM pipeline register for the rv32i core.
- Selects operands through forwarding muxes, drives the existing combinational `alu` (opcode type `alu_op_t`), and registers the results into the memory stage.
- Adds stall, flush, valid tracking and synchronous reset to the plain one-cycle EX→MEM register.
- Sits between the ID/EX register and data memory; the hazard unit drives the stall, flush and forward controls.

Parameters:
- DPW, 32, datapath width in bits.
- RAW, 5, register-file address width.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall_i  in  1  hold the EX/MEM register contents.
- flush_i  in  1  insert a bubble into MEM.
- validE  in  1  instruction in EX is valid.
- regwriteE  in  1  register-file write enable.
- resultsrcE  in  1  result source select, passed to MEM/WB.
- memwriteE  in  1  data-memory write enable.
- alu_ctrlE  in  alu_op_t  ALU operation.
- alusrcE  in  1  ALU operand B select: 0 = forwarded Rd2, 1 = immediate.
- Rd1E  in  DPW  register-file read data 1.
- Rd2E  in  DPW  register-file read data 2.
- RdE  in  RAW  destination register.
- immextE  in  DPW  sign-extended immediate.
- forwardAE  in  2  operand A forward select.
- forwardBE  in  2  operand B forward select.
- resultW  in  DPW  writeback result, used for forwarding.
- validM  out  1  MEM stage holds a valid instruction.
- regwriteM  out  1  registered register-file write enable.
- resultsrcM  out  1  registered result source select.
- memwriteM  out  1  registered memory write enable.
- aluresultM  out  DPW  registered ALU result.
- writedataM  out  DPW  registered store data (forwarded Rd2).
- RdM  out  RAW  registered destination register.
- srcBE  out  DPW  ALU operand B; test observation only.
- stall_cnt  out  CNT_W  stall-cycle count; present only with the macro.
- flush_cnt  out  CNT_W  flush-cycle count; present only with the macro.

Behaviour:
- Combinational path:
  - srcA = Rd1E when forwardAE=00; resultW when 01; aluresultM when 10; Rd1E when 11 (reserved).
  - fwdB is selected by forwardBE with the same encoding, using Rd2E as the default.
  - srcBE = alusrcE ? immextE : fwdB.
  - The ALU computes aluresultE from srcA, srcBE and alu_ctrlE.
- Latency: 1 cycle from EX to the MEM outputs.
- Register update priority on each rising edge of clk: reset > flush > stall > load.
- Reset (rst_n=0 at the edge): every registered output is cleared to 0, including validM, the control bits, aluresultM, writedataM, RdM and the counters. Reset asserted mid-stall or mid-flush still clears everything on that edge.
- Flush (flush_i=1): validM, regwriteM, memwriteM, resultsrcM, RdM, aluresultM and writedataM are all written to 0.
  - Flush wins over a simultaneous stall_i.
- Stall (stall_i=1, flush_i=0): every registered output holds its value.
  - aluresultM therefore stays stable while it is being forwarded back to EX.
- Load (neither stall nor flush):
  - validM ← validE.
  - regwriteM ← regwriteE & validE & (RdE≠0).
  - memwriteM ← memwriteE & validE.
  - resultsrcM ← resultsrcE.
  - aluresultM ← aluresultE.
  - writedataM ← fwdB.
  - RdM ← RdE.
  - An invalid instruction (validE=0) still loads its data fields, but its write enables are gated to 0.
- Writes to x0 never assert regwriteM.
- Arithmetic wraps modulo 2^DPW, as defined by `alu`; there is no overflow output.
- No internal state other than the EX/MEM register and the optional counters.

Optional Feature:
- Macro EX_MEM_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each edge where rst_n=1, stall_i=1 and flush_i=0.
  - flush_cnt increments on each edge where rst_n=1 and flush_i=1.
  - Both counters saturate at 2^CNT_W−1 and clear on reset.
  - The stall_cnt and flush_cnt ports exist.
- Undefined: the counters and their ports are absent; the rest of the behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all inputs = 1 → all outputs 0. Release rst_n; load ADD with Rd1E=5, Rd2E=7 → aluresultM=12, validM=1 one cycle later.
- Forwarding: forwardAE=10 with aluresultM=0x10, forwardBE=01 with resultW=0x3, ADD, alusrcE=0 → next aluresultM=0x13, writedataM=0x3. Repeat with forwardAE=11 → uses Rd1E.
- Immediate select: alusrcE=1, immextE=0xFFFFFFFC, Rd1E=8, ADD → srcBE=0xFFFFFFFC, aluresultM=4, writedataM=fwdB (unchanged from Rd2E).
- Stall and flush:
  - stall_i=1 for 3 cycles while inputs change → outputs frozen.
  - stall_i=1 and flush_i=1 together → bubble: validM=0, regwriteM=0, memwriteM=0, aluresultM=0.
- Gating: regwriteE=1, RdE=0 → regwriteM=0. validE=0, memwriteE=1 → memwriteM=0, validM=0.
- With EX_MEM_PERF_CNT_EN and CNT_W=2: 5 stall cycles → stall_cnt=3 (saturated); 2 flush cycles → flush_cnt=2; reset → both 0.
